friet_permutation_axi4_lite_master_sequencer: RTL and testbench

AXI4-Lite master that drives the protected Friet permutation AXI4-Lite slave on behalf of a local client. It accepts a 384-bit state over a valid/ready port and writes it as 12 32-bit words to the slave's data-in register, then issues the start command. It reads the permuted state back as 12 words, reads the fault register, and returns the result, fault flag and AXI error flag over a valid/ready output port.

---
 rtl/friet_permutation_axi4_lite_master_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_friet_permutation_axi4_lite_master_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friet_permutation_axi4_lite_master_sequencer.sv
// AXI4-Lite master sequencing one Friet permutation job on the slave:
// 12 data writes, start write, 12 data reads, fault read, then result out.
module friet_permutation_axi4_lite_master_sequencer #(
    parameter int         STATE_WORDS   = 12,
    parameter logic [3:0] ADDR_DATA_IN  = 4'h4,
    parameter logic [3:0] ADDR_START    = 4'h8,
    parameter logic [3:0] ADDR_DATA_OUT = 4'h0,
    parameter logic [3:0] ADDR_FAULT    = 4'hB
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*STATE_WORDS-1:0] in_state,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [32*STATE_WORDS-1:0] out_state,
    output logic                      out_fault,
    output logic                      out_resp_err,
    output logic [3:0]                m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [3:0]                m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int SW = 32 * STATE_WORDS;
    localparam int CW = $clog2(STATE_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_DATA, PH_START, PH_FAULT} phase_t;

    state_t         r_state, w_state_nxt;
    phase_t         r_ph;
    logic [CW-1:0]  r_wcnt;
    logic [SW-1:0]  r_shift, r_out_state;
    logic           r_in_ready, r_out_valid, r_fault, r_resp_err;
    logic           r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic           r_aw_done, r_w_done;
    logic [3:0]     r_awaddr, r_araddr;
    logic [31:0]    r_wdata;
    logic           w_in_hs, w_aw_hs, w_w_hs, w_ar_hs, w_wr_done, w_last;

    assign w_in_hs   = in_valid && r_in_ready;
    assign w_aw_hs   = r_awvalid && m_axi_awready;
    assign w_w_hs    = r_wvalid && m_axi_wready;
    assign w_ar_hs   = r_arvalid && m_axi_arready;
    assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_last    = (r_wcnt == CW'(STATE_WORDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    if (w_in_hs) w_state_nxt = S_WR_REQ;
            S_WR_REQ:  if (w_wr_done) w_state_nxt = S_WR_RESP;
            S_WR_RESP: if (m_axi_bvalid)
                           w_state_nxt = (r_ph == PH_START) ? S_RD_REQ : S_WR_REQ;
            S_RD_REQ:  if (w_ar_hs) w_state_nxt = S_RD_DATA;
            S_RD_DATA: if (m_axi_rvalid)
                           w_state_nxt = (r_ph == PH_FAULT) ? S_DONE : S_RD_REQ;
            S_DONE:    if (out_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ph        <= PH_DATA;
            r_wcnt      <= '0;
            r_shift     <= '0;
            r_out_state <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_fault     <= 1'b0;
            r_resp_err  <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            unique case (r_state)
                S_IDLE: if (w_in_hs) begin
                    r_shift    <= in_state;
                    r_wcnt     <= '0;
                    r_ph       <= PH_DATA;
                    r_resp_err <= 1'b0;
                    r_awvalid  <= 1'b1;
                    r_wvalid   <= 1'b1;
                    r_awaddr   <= ADDR_DATA_IN;
                    r_wdata    <= in_state[31:0];
                    r_aw_done  <= 1'b0;
                    r_w_done   <= 1'b0;
                end
                S_WR_REQ: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_wr_done) r_bready <= 1'b1;
                end
                S_WR_RESP: if (m_axi_bvalid) begin
                    r_bready  <= 1'b0;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    if (m_axi_bresp != 2'b00) r_resp_err <= 1'b1;
                    if (r_ph == PH_START) begin
                        r_wcnt    <= '0;
                        r_arvalid <= 1'b1;
                        r_araddr  <= ADDR_DATA_OUT;
                    end else begin
                        r_shift   <= r_shift >> 32;
                        r_wcnt    <= r_wcnt + CW'(1);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        // After the last data word the start command follows
                        if (w_last) begin
                            r_ph     <= PH_START;
                            r_awaddr <= ADDR_START;
                            r_wdata  <= 32'h1;
                        end else begin
                            r_awaddr <= ADDR_DATA_IN;
                            r_wdata  <= r_shift[63:32];
                        end
                    end
                end
                S_RD_REQ: if (w_ar_hs) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                end
                S_RD_DATA: if (m_axi_rvalid) begin
                    r_rready <= 1'b0;
                    if (m_axi_rresp != 2'b00) r_resp_err <= 1'b1;
                    if (r_ph == PH_FAULT) begin
                        r_fault <= m_axi_rdata[0];
                    end else begin
                        for (int k = 0; k < STATE_WORDS; k++)
                            if (r_wcnt == CW'(k))
                                r_out_state[32*k +: 32] <= m_axi_rdata;
                        r_wcnt    <= r_wcnt + CW'(1);
                        r_arvalid <= 1'b1;
                        if (w_last) begin
                            r_ph     <= PH_FAULT;
                            r_araddr <= ADDR_FAULT;
                        end else begin
                            r_araddr <= ADDR_DATA_OUT;
                        end
                    end
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_state     = r_out_state;
    assign out_fault     = r_fault;
    assign out_resp_err  = r_resp_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_friet_permutation_axi4_lite_master_sequencer.sv
// Bench for the Friet AXI4-Lite master sequencer: reactive slave model,
// job-level reference model and per-cycle output comparison.
module tb_friet_permutation_axi4_lite_master_sequencer;

  logic aclk, aresetn;
  logic in_valid, in_ready, out_valid, out_ready, out_fault, out_resp_err;
  logic [383:0] in_state, out_state;
  logic [3:0] m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [1:0] m_axi_bresp, m_axi_rresp;

  friet_permutation_axi4_lite_master_sequencer dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_fault(out_fault), .out_resp_err(out_resp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [383:0] act,
                       input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference permutation stand-in the slave applies to a full state
  function automatic logic [383:0] friet_ref(input logic [383:0] s);
    logic [31:0] a, b;
    friet_ref = '0;
    for (int k = 0; k < 12; k++) begin
      a = s[32*((k+1)%12) +: 32];
      b = s[32*k +: 32];
      friet_ref[32*k +: 32] = {a[24:0], a[31:25]} ^ b ^ (32'h9E3779B9 + 32'(k));
    end
  endfunction

  function automatic logic [383:0] rnd_state();
    for (int k = 0; k < 12; k++) rnd_state[32*k +: 32] = $urandom();
  endfunction

  // slave configuration and logs
  int cfg_err_wr = -1, cfg_err_rd = -1, cfg_stall_idx = -1;
  bit cfg_fault = 0, cfg_rand = 0, stall_done = 0, saw_w_first = 0;
  int bcnt = 0, rcnt = 0;
  logic [3:0]  wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [3:0]  rlog_a[$];

  // expected job result
  logic [383:0] exp_state = '0;
  bit exp_fault = 0, exp_err = 0;

  initial begin : slave
    bit aw_f, w_f, b_f, ar_f, r_f, have_aw, have_w, b_pend, r_pend;
    bit p_awv, p_wv, p_arv;
    logic [3:0] p_awaddr, p_araddr, aw_a;
    logic [31:0] p_wdata, w_d, tmp, r_n;
    logic [1:0] b_n, rr_n;
    logic [31:0] sin[12];
    logic [31:0] sout[12];
    logic [383:0] pk;
    int b_wait, r_wait, aw_stall, wi, ri;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0;
    m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        {aw_f, w_f, b_f, ar_f, r_f} = '0;
        {have_aw, have_w, b_pend, r_pend, p_awv, p_wv, p_arv} = '0;
        aw_stall = 0; wi = 0; ri = 0;
        continue;
      end
      // a valid that was not accepted must stay up with stable payload
      if (p_awv && !aw_f)
        check("awvalid_held", {m_axi_awvalid, m_axi_awaddr}, {1'b1, p_awaddr});
      if (p_wv && !w_f)
        check("wvalid_held", {m_axi_wvalid, m_axi_wdata}, {1'b1, p_wdata});
      if (p_arv && !ar_f)
        check("arvalid_held", {m_axi_arvalid, m_axi_araddr}, {1'b1, p_araddr});
      if (m_axi_awvalid || m_axi_wvalid)
        check("prot_strb", {m_axi_awprot, m_axi_wstrb, m_axi_arprot},
              {3'b000, 4'hF, 3'b000});
      if (b_f) m_axi_bvalid = 0;
      if (r_f) m_axi_rvalid = 0;
      if (aw_f) begin have_aw = 1; aw_a = p_awaddr; end
      if (w_f) begin have_w = 1; w_d = p_wdata; end
      if (have_aw && have_w) begin
        wlog_a.push_back(aw_a);
        wlog_d.push_back(w_d);
        if (aw_a == 4'h4 && wi < 12) begin sin[wi] = w_d; wi++; end
        if (aw_a == 4'h8) begin
          for (int k = 0; k < 12; k++) pk[32*k +: 32] = sin[k];
          pk = friet_ref(pk);
          for (int k = 0; k < 12; k++) sout[k] = pk[32*k +: 32];
          wi = 0; ri = 0;
        end
        b_n = (wlog_a.size() - 1 == cfg_err_wr) ? 2'b10 : 2'b00;
        b_wait = cfg_rand ? int'($urandom_range(0, 2)) : 0;
        b_pend = 1; have_aw = 0; have_w = 0;
      end
      if (b_pend) begin
        if (b_wait == 0) begin
          m_axi_bvalid = 1; m_axi_bresp = b_n; b_pend = 0;
        end else b_wait--;
      end
      if (ar_f) begin
        rlog_a.push_back(p_araddr);
        tmp = $urandom();
        if (p_araddr == 4'h0) begin
          r_n = (ri < 12) ? sout[ri] : tmp;
          ri++;
        end else if (p_araddr == 4'hB) r_n = {tmp[31:1], cfg_fault};
        else r_n = tmp;
        rr_n = (rlog_a.size() - 1 == cfg_err_rd) ? 2'b10 : 2'b00;
        r_wait = cfg_rand ? int'($urandom_range(0, 2)) : 0;
        r_pend = 1;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          m_axi_rvalid = 1; m_axi_rdata = r_n; m_axi_rresp = rr_n; r_pend = 0;
        end else r_wait--;
      end
      if (have_w && !have_aw && m_axi_awvalid && !m_axi_wvalid)
        saw_w_first = 1;
      if (m_axi_awvalid && !p_awv && !stall_done &&
          wlog_a.size() == cfg_stall_idx) begin
        aw_stall = 5; stall_done = 1;
      end
      m_axi_awready = (aw_stall > 0) ? 1'b0
                    : (cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (aw_stall > 0) aw_stall--;
      m_axi_wready = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_arready = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      aw_f = m_axi_awvalid && m_axi_awready;
      w_f = m_axi_wvalid && m_axi_wready;
      ar_f = m_axi_arvalid && m_axi_arready;
      b_f = m_axi_bvalid && m_axi_bready;
      r_f = m_axi_rvalid && m_axi_rready;
      if (b_f) bcnt++;
      if (r_f) rcnt++;
      p_awv = m_axi_awvalid; p_awaddr = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wdata = m_axi_wdata;
      p_arv = m_axi_arvalid; p_araddr = m_axi_araddr;
    end
  end

  // outputs checked against the model whenever a result is presented
  always @(negedge aclk) begin
    if (aresetn && out_valid) begin
      check("out_state", out_state, exp_state);
      check("out_fault", out_fault, exp_fault);
      check("out_resp_err", out_resp_err, exp_err);
      check("in_ready_while_out", in_ready, 0);
    end
  end

  task automatic start_job(input logic [383:0] st, input int ewr,
                           input int erd, input bit flt, input bit rm,
                           input int stidx);
    int n;
    cfg_err_wr = ewr; cfg_err_rd = erd; cfg_fault = flt;
    cfg_rand = rm; cfg_stall_idx = stidx;
    stall_done = 0; saw_w_first = 0;
    wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
    bcnt = 0; rcnt = 0;
    exp_state = friet_ref(st);
    exp_fault = flt;
    exp_err = (ewr >= 0) || (erd >= 0);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge aclk); n++; end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; in_state = st;
    @(negedge aclk);
    in_valid = 0; in_state = rnd_state();
  endtask

  task automatic run_job(input logic [383:0] st, input int ewr,
                         input int erd, input bit flt, input bit rm,
                         input int stidx, input int stall, output int lat);
    int bad_w, bad_r;
    start_job(st, ewr, erd, flt, rm, stidx);
    lat = 0;
    while (!out_valid && lat < 4000) begin @(negedge aclk); lat++; end
    check("out_valid_arrives", out_valid, 1);
    for (int i = 0; i < stall; i++) begin
      check("in_ready_during_done", in_ready, 0);
      @(negedge aclk);
    end
    out_ready = 1;
    @(negedge aclk);
    out_ready = 0;
    check("in_ready_after_done", in_ready, 1);
    check("out_valid_dropped", out_valid, 0);
    bad_w = -1; bad_r = -1;
    for (int k = 0; k < 13; k++) begin
      if (bad_w < 0 && (k >= wlog_a.size() ||
          wlog_a[k] != ((k < 12) ? 4'h4 : 4'h8) ||
          wlog_d[k] != ((k < 12) ? st[32*k +: 32] : 32'h1))) bad_w = k;
      if (bad_r < 0 && (k >= rlog_a.size() ||
          rlog_a[k] != ((k < 12) ? 4'h0 : 4'hB))) bad_r = k;
    end
    check("write_seq_bad_idx", bad_w, -1);
    check("read_seq_bad_idx", bad_r, -1);
    check("write_count", wlog_a.size(), 13);
    check("read_count", rlog_a.size(), 13);
    check("b_count", bcnt, 13);
    check("r_count", rcnt, 13);
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
               m_axi_rready, m_axi_awaddr, m_axi_araddr, m_axi_wdata,
               m_axi_wstrb, in_ready, out_valid, out_fault, out_resp_err},
          {5'b0, 4'h0, 4'h0, 32'h0, 4'hF, 4'b0000});
    check({nm, "_state"}, out_state, '0);
  endtask

  initial begin
    logic [383:0] st;
    int lat, n;
    aresetn = 0; in_valid = 0; out_ready = 0; in_state = '0;
    repeat (3) @(negedge aclk);
    check_reset_outputs("reset_values");
    // hand-computed values pinning the reference model
    st = '0;
    check("ref_zero_w0", friet_ref(st) & 384'hFFFFFFFF, 384'h9E3779B9);
    check("ref_zero_w11", friet_ref(st) >> 352, 384'h9E3779C4);
    st[0] = 1'b1;
    check("ref_one_w0", friet_ref(st) & 384'hFFFFFFFF, 384'h9E3779B8);
    check("ref_one_w11", friet_ref(st) >> 352, 384'h9E377944);
    aresetn = 1;
    @(negedge aclk);
    check("in_ready_after_reset", in_ready, 1);

    // known answer, zero-wait slave, latency window
    run_job('0, -1, -1, 0, 0, -1, 0, lat);
    check("latency_52_54", (lat >= 52 && lat <= 54), 1);

    // word order
    for (int k = 0; k < 12; k++) st[32*k +: 32] = 32'h1000_0000 + 32'(k);
    run_job(st, -1, -1, 0, 0, -1, 0, lat);
    check("word11_data", wlog_d[11], 32'h1000000B);
    check("start_write", {wlog_a[12], wlog_d[12]}, {4'h8, 32'h1});

    // AW backpressure with W accepted first
    run_job(rnd_state(), -1, -1, 0, 0, 2, 0, lat);
    check("w_before_aw", saw_w_first, 1);

    // error response plus fault flag, then a clean job
    run_job(rnd_state(), 3, -1, 1, 0, -1, 0, lat);
    run_job(rnd_state(), -1, -1, 0, 0, -1, 0, lat);

    // output stall in DONE
    run_job(rnd_state(), -1, 7, 0, 1, -1, 10, lat);

    // reset in the middle of the read phase
    start_job(rnd_state(), -1, -1, 0, 0, -1);
    n = 0;
    while (rlog_a.size() < 5 && n < 2000) begin @(negedge aclk); n++; end
    check("reached_read5", rlog_a.size() >= 5, 1);
    #2 aresetn = 0;
    #1 check_reset_outputs("midjob_reset");
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    check("in_ready_after_midreset", in_ready, 1);
    run_job(rnd_state(), -1, -1, 1, 0, -1, 0, lat);

    // randomized jobs against a randomized slave
    for (int j = 0; j < 8; j++) begin
      run_job(rnd_state(),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1,
              1'($urandom_range(0, 1)), 1,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 12)) : -1,
              int'($urandom_range(0, 4)), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
